// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave.
// Holds the transfer enums, response codes, the slave FSM state type and
// the byte-strobe / alignment helpers used by the data-phase logic.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    localparam logic AHB_OKAY  = 1'b0;
    localparam logic AHB_ERROR = 1'b1;

    localparam int unsigned WAIT_CNT_W = 4;

    // Byte strobe for a transfer of size hsize starting at byte lane addr_lsb.
    // Result is 8 lanes wide; callers truncate to their own lane count.
    function automatic logic [7:0] size_to_strb(input logic [2:0]  hsize,
                                                input logic [2:0]  addr_lsb,
                                                input int unsigned data_width);
        logic [7:0] base;
        logic [7:0] full;
        full = (data_width == 64) ? 8'hFF : 8'h0F;
        case (hsize)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return (base << addr_lsb) & full;
    endfunction

    // Low address bits that must be zero for a transfer of size hsize.
    function automatic logic [2:0] align_mask(input logic [2:0] hsize);
        case (hsize)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised SRAM bank: DEPTH x WIDTH, per-byte write enables,
// registered read. One write port and one read port so a committing write
// and a newly accepted read can share a clock edge; a read of the word being
// written returns the old contents (the slave forwards the new bytes).
// Ports: clk; we/waddr/wstrb/wdata write side; re/raddr read request;
// rdata holds the last word read until the next re.
module ahb_sram_bank #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    input  logic [IDX_W-1:0]   raddr,
    output logic [WIDTH-1:0]   rdata
);

    localparam int unsigned BYTES = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Read data updates only on a read request, otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage has no reset; contents survive hresetn.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM.
// One outstanding transfer, pipelined address/data phases, configurable
// wait states on OKAY transfers and a two-cycle ERROR response for
// out-of-range, oversize or misaligned accesses.
// Ports: hclk/hresetn (sync, active-low); AHB address phase inputs hsel,
// haddr, htrans, hsize, hburst, hwrite, hready; hwdata in data phase;
// outputs hrdata, hreadyout, hresp.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned LANE_W     = $clog2(BYTES);
    localparam int unsigned BYTE_RANGE = MEM_DEPTH * BYTES;
    localparam int unsigned ADDR_HI    = $clog2(BYTE_RANGE);
    localparam int unsigned IDX_W      = ADDR_HI - LANE_W;
    localparam logic [ADDR_WIDTH:0] RANGE_LIM = (ADDR_WIDTH + 1)'(BYTE_RANGE);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic                  dp_wr_q, dp_wr_d;
    logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
    logic [LANE_W-1:0]     dp_lsb_q, dp_lsb_d;
    logic [2:0]            dp_size_q, dp_size_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [BYTES-1:0]      fwd_strb_q, fwd_strb_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    htrans_t               trans_c;
    hburst_t               burst_unused;
    logic                  accept_c;
    logic                  err_c;
    logic [IDX_W-1:0]      idx_c;
    logic [BYTES-1:0]      wr_strb_c;
    logic                  commit_c;
    logic                  rd_en_c;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic [DATA_WIDTH-1:0] hrdata_c;

    assign trans_c      = htrans_t'(htrans);
    assign burst_unused = hburst_t'(hburst);

    // Address-phase decode. Only sampled while our own data phase completes.
    always_comb begin
        accept_c = hsel && hready && hreadyout_q &&
                   (trans_c == HTRANS_NONSEQ || trans_c == HTRANS_SEQ);
        err_c    = ({1'b0, haddr} >= RANGE_LIM) ||
                   (hsize > 3'(LANE_W)) ||
                   (|(haddr[2:0] & align_mask(hsize)));
        idx_c    = haddr[ADDR_HI-1:LANE_W];
        rd_en_c  = accept_c && !hwrite && !err_c;
    end

    // Data-phase write: commits on the edge where hreadyout is high.
    always_comb begin
        wr_strb_c = BYTES'(size_to_strb(dp_size_q, 3'(dp_lsb_q), DATA_WIDTH));
        commit_c  = hreadyout_q && dp_wr_q;
    end

    ahb_sram_bank #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk   (hclk),
        .we    (commit_c),
        .waddr (dp_idx_q),
        .wstrb (wr_strb_c),
        .wdata (hwdata),
        .re    (rd_en_c),
        .raddr (idx_c),
        .rdata (bank_rdata)
    );

    // FSM next state, wait counter and registered response outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = 1'b1;
        hresp_d     = AHB_OKAY;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    if (err_c) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_WAIT: begin hreadyout_d = 1'b0; hresp_d = AHB_OKAY;  end
            ST_ERR1: begin hreadyout_d = 1'b0; hresp_d = AHB_ERROR; end
            ST_ERR2: begin hreadyout_d = 1'b1; hresp_d = AHB_ERROR; end
            default: begin hreadyout_d = 1'b1; hresp_d = AHB_OKAY;  end
        endcase
    end

    // Data-phase register and read-forwarding capture.
    always_comb begin
        dp_wr_d    = dp_wr_q;
        dp_idx_d   = dp_idx_q;
        dp_lsb_d   = dp_lsb_q;
        dp_size_d  = dp_size_q;
        rd_valid_d = rd_valid_q;
        fwd_strb_d = fwd_strb_q;
        fwd_data_d = fwd_data_q;
        if (hreadyout_q) begin
            dp_wr_d = accept_c && hwrite && !err_c;
        end
        if (accept_c) begin
            dp_idx_d   = idx_c;
            dp_lsb_d   = haddr[LANE_W-1:0];
            dp_size_d  = hsize;
            rd_valid_d = !hwrite && !err_c;
        end
        // Bank returns pre-write data when the read hits the word being written.
        if (rd_en_c) begin
            fwd_strb_d = (commit_c && (dp_idx_q == idx_c)) ? wr_strb_c : '0;
            fwd_data_d = hwdata;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= AHB_OKAY;
            dp_wr_q     <= 1'b0;
            dp_idx_q    <= '0;
            dp_lsb_q    <= '0;
            dp_size_q   <= '0;
            rd_valid_q  <= 1'b0;
            fwd_strb_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            dp_wr_q     <= dp_wr_d;
            dp_idx_q    <= dp_idx_d;
            dp_lsb_q    <= dp_lsb_d;
            dp_size_q   <= dp_size_d;
            rd_valid_q  <= rd_valid_d;
            fwd_strb_q  <= fwd_strb_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // Read data: bank word with forwarded bytes merged; zero unless an OKAY read.
    always_comb begin
        hrdata_c = '0;
        if (rd_valid_q) begin
            for (int b = 0; b < BYTES; b++) begin
                hrdata_c[8*b +: 8] = fwd_strb_q[b] ? fwd_data_q[8*b +: 8]
                                                   : bank_rdata[8*b +: 8];
            end
        end
    end

    assign hrdata    = hrdata_c;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule
